// File: rtl/apb_wait_slave.sv
// APB completer: register file with a WAIT_CFG register at the top address.
// Transfers insert W programmable wait states.
// Addresses at or above DEPTH complete with pslverr.
module apb_wait_slave #(
  parameter int         DEPTH        = 16,
  parameter logic [1:0] WAIT_DEFAULT = 2'd1
) (
  input  logic       pclk,
  input  logic       prstn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         NREG     = 1 << AW;
  localparam logic [8:0] DEPTH_W  = 9'(DEPTH);
  localparam logic [8:0] CFG_ADDR = 9'(DEPTH - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_mem_q, wr_mem_d;
  logic          wr_cfg_q, wr_cfg_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [7:0]    mem_q [0:NREG-1];
  logic [1:0]    wait_q;
  logic          complete;
  logic          in_range;
  logic          is_cfg;
  logic [7:0]    rd_val;

  // Outputs come straight from registered state; no path from the APB inputs.
  assign prdata  = rdata_q;
  assign pslverr = err_q;
  assign pready  = (state_q == ACCESS) && (cnt_q == 2'd0);

  // Decode the setup-phase address and look up read data.
  always_comb begin
    in_range = ({1'b0, paddr} < DEPTH_W);
    is_cfg   = ({1'b0, paddr} == CFG_ADDR);
    rd_val   = 8'h00;
    if (is_cfg) begin
      rd_val = {6'b0, wait_q};
    end else if (in_range) begin
      rd_val = mem_q[paddr[AW-1:0]];
    end
  end

  // Transfer FSM: setup captures the whole transaction, ACCESS counts down the waits.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wr_mem_d = wr_mem_q;
    wr_cfg_d = wr_cfg_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        // An enable without a preceding setup phase is ignored.
        if (psel && !penable) begin
          state_d  = ACCESS;
          cnt_d    = wait_q;
          addr_d   = paddr[AW-1:0];
          wr_mem_d = pwrite && in_range && !is_cfg;
          wr_cfg_d = pwrite && is_cfg;
          wdata_d  = pwdata;
          rdata_d  = pwrite ? 8'h00 : rd_val;
          err_d    = !in_range;
        end
      end
      default: begin
        if (!psel) begin
          // Master abort: drop the transfer without touching the register file.
          state_d = IDLE;
          cnt_d   = 2'd0;
          rdata_d = 8'h00;
          err_d   = 1'b0;
        end else if (penable) begin
          if (cnt_q == 2'd0) begin
            complete = 1'b1;
            state_d  = IDLE;
            rdata_d  = 8'h00;
            err_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
    endcase
  end

  // Control and response registers.
  always_ff @(posedge pclk) begin
    if (prstn) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      wr_mem_q <= 1'b0;
      wr_cfg_q <= 1'b0;
      rdata_q  <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_mem_q <= wr_mem_d;
      wr_cfg_q <= wr_cfg_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Latched address and write data; only consumed together with the write flags.
  always_ff @(posedge pclk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Register file and WAIT_CFG update on the completion edge.
  always_ff @(posedge pclk) begin
    if (prstn) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= 8'h00;
      end
      wait_q <= WAIT_DEFAULT;
    end else if (complete) begin
      if (wr_mem_q) begin
        mem_q[addr_q] <= wdata_q;
      end
      if (wr_cfg_q) begin
        wait_q <= wdata_q[1:0];
      end
    end
  end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed plus randomized bench for apb_wait_slave against a register-map model.
module tb_apb_wait_slave;

  logic       pclk    = 1'b0;
  logic       prstn   = 1'b1;
  logic       psel    = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite  = 1'b0;
  logic [7:0] paddr   = 8'h00;
  logic [7:0] pwdata  = 8'h00;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  int vectors     = 0;
  int miscompares = 0;

  // Model: entries 0..14 are data registers, entry 15 holds W.
  logic [7:0] ref_mem [0:15];

  apb_wait_slave #(.DEPTH(16), .WAIT_DEFAULT(2'd1)) dut (
    .pclk(pclk), .prstn(prstn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    ref_mem[15] = 8'h01;
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset(input int n);
    prstn = 1'b1;
    repeat (n) step();
    prstn = 1'b0;
    model_reset();
  endtask

  // Called one time unit after a rising edge. mode: 0 normal, 1 abort, 2 reset,
  // the disturbance being applied in wait cycle number 'at'.
  task automatic xfer(input logic [7:0] a, input logic wr, input logic [7:0] d,
                      input int mode, input int at);
    int         w;
    int         waits;
    bit         done;
    logic       err;
    logic [7:0] exp_rd;
    w      = int'(ref_mem[15]);
    err    = (a >= 8'd16);
    exp_rd = (wr || err) ? 8'h00 : ref_mem[a[3:0]];
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge pclk);
    chk("setup_pready", {7'b0, pready}, 8'h00);
    chk("setup_prdata", prdata, 8'h00);
    step();
    penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge pclk);
      if (pready === 1'b1) begin
        chk("latency", 8'(waits), 8'(w));
        chk("pslverr", {7'b0, pslverr}, {7'b0, err});
        if (!wr) chk("rdata", prdata, exp_rd);
        done = 1'b1;
        step();
      end else begin
        if (!wr) chk("wait_prdata", prdata, exp_rd);
        if (mode != 0 && waits == at) begin
          if (mode == 1) begin
            psel = 1'b0; penable = 1'b0;
          end else begin
            prstn = 1'b1;
          end
          step();
          prstn = 1'b0;
          if (mode == 2) model_reset();
          @(negedge pclk);
          chk("abort_pready", {7'b0, pready}, 8'h00);
          chk("abort_prdata", prdata, 8'h00);
          psel = 1'b0; penable = 1'b0;
          step();
          return;
        end
        waits++;
        step();
      end
    end
    if (!done) chk("timeout", 8'h00, 8'h01);
    psel = 1'b0; penable = 1'b0;
    if (done && wr && !err) ref_mem[a[3:0]] = (a == 8'd15) ? {6'b0, d[1:0]} : d;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rd;
    logic       rw;

    // Reset defaults
    model_reset();
    do_reset(2);
    @(negedge pclk);
    chk("rst_pready", {7'b0, pready}, 8'h00);
    chk("rst_pslverr", {7'b0, pslverr}, 8'h00);
    chk("rst_prdata", prdata, 8'h00);
    step();
    xfer(8'd15, 1'b0, 8'h00, 0, 0);

    // Zero-wait round trip
    xfer(8'd15, 1'b1, 8'h00, 0, 0);
    xfer(8'd3, 1'b1, 8'hA5, 0, 0);
    xfer(8'd3, 1'b0, 8'h00, 0, 0);

    // Maximum wait
    xfer(8'd15, 1'b1, 8'hFF, 0, 0);
    xfer(8'd15, 1'b0, 8'h00, 0, 0);
    xfer(8'd3, 1'b0, 8'h00, 0, 0);

    // Out-of-range access, then every in-range register
    xfer(8'h20, 1'b1, 8'h5A, 0, 0);
    xfer(8'h20, 1'b0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) xfer(8'(i), 1'b0, 8'h00, 0, 0);

    // Abort and reset mid-transfer
    xfer(8'd15, 1'b1, 8'h02, 0, 0);
    xfer(8'd5, 1'b1, 8'h11, 0, 0);
    xfer(8'd5, 1'b1, 8'h77, 1, 1);
    xfer(8'd5, 1'b0, 8'h00, 0, 0);
    xfer(8'd5, 1'b1, 8'h77, 2, 1);
    xfer(8'd5, 1'b0, 8'h00, 0, 0);
    xfer(8'd15, 1'b0, 8'h00, 0, 0);

    // Back-to-back zero-wait writes
    xfer(8'd15, 1'b1, 8'h00, 0, 0);
    xfer(8'd1, 1'b1, 8'h3C, 0, 0);
    xfer(8'd2, 1'b1, 8'hC3, 0, 0);
    xfer(8'd1, 1'b0, 8'h00, 0, 0);
    xfer(8'd2, 1'b0, 8'h00, 0, 0);

    // Spurious enable without setup
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd4; pwdata = 8'hEE;
    repeat (3) begin
      @(negedge pclk);
      chk("spurious_pready", {7'b0, pready}, 8'h00);
      step();
    end
    psel = 1'b0; penable = 1'b0;
    step();
    xfer(8'd4, 1'b0, 8'h00, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        xfer(8'd15, 1'b1, 8'($urandom), 0, 0);
      end
      ra = 8'($urandom_range(0, 23));
      rw = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      xfer(ra, rw, rd, 0, 0);
      repeat ($urandom_range(0, 2)) step();
    end
    for (int i = 0; i < 16; i++) xfer(8'(i), 1'b0, 8'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
